// File: rtl/encoder_16x4_seq_if.sv
// encoder_16x4_seq_if
// Bundles the request-vector handshake and the index-output handshake of the
// sequential 16-to-4 encoder.
//   in_valid/in/in_ready          : request vector from the producer
//   out_valid/out/out_last/out_ready : one encoded index per handshake
//   out_count                      : set-bit count of the last accepted vector
//   zero_err                       : one-cycle pulse on an all-zero vector
// Modports:
//   slave  : the encoder itself
//   master : the producer/consumer environment around it
interface encoder_16x4_seq_if;
  logic        in_valid;
  logic [15:0] in;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out;
  logic        out_last;
  logic        out_ready;
  logic [4:0]  out_count;
  logic        zero_err;

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_last, out_count, zero_err
  );

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_last, out_count, zero_err
  );
endinterface

// File: rtl/encoder_16x4_seq.sv
// encoder_16x4_seq
// Sequential 16-to-4 encoder. A non-zero request vector is captured over a
// valid/ready handshake and then drained one set bit per output handshake,
// lowest index first (LSB_FIRST=1) or highest index first (LSB_FIRST=0).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : encoder_16x4_seq_if.slave (request vector in, encoded index out,
//         out_count and zero_err status)
module encoder_16x4_seq #(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  encoder_16x4_seq_if.slave    bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  out_count_q, out_count_d;
  logic        zero_err_q, zero_err_d;

  logic [3:0]  sel_idx;
  logic        single_bit;
  logic [4:0]  in_popcount;

  // Priority select over the pending register. The scan visits bits in the
  // reverse of the emission order so the last hit is the winning index.
  always_comb begin
    sel_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      int j;
      j = LSB_FIRST ? (15 - i) : i;
      if (pending_q[j]) sel_idx = j[3:0];
    end
  end

  // Popcount of the incoming vector, only used on the accept edge.
  always_comb begin
    in_popcount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      in_popcount = in_popcount + {4'd0, bus.in[i]};
    end
  end

  // Clearing the lowest set bit leaves zero only when one bit remains.
  assign single_bit = ((pending_q & (pending_q - 16'd1)) == 16'd0);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_count_d = out_count_q;
    zero_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in != 16'd0) begin
            pending_d   = bus.in;
            out_count_d = in_popcount;
            state_d     = EMIT;
          end else begin
            out_count_d = 5'd0;
            zero_err_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        // out_valid is always high here, so out_ready alone completes a handshake.
        if (bus.out_ready) begin
          pending_d = pending_q & ~(16'd1 << sel_idx);
          if (single_bit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 16'd0;
      out_count_q <= 5'd0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_count_q <= out_count_d;
      zero_err_q  <= zero_err_d;
    end
  end

  // in_ready is gated by rst so the producer sees "not ready" for the whole
  // reset window, not just after the first reset edge.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out       = (state_q == EMIT) ? sel_idx : 4'd0;
  assign bus.out_last  = (state_q == EMIT) && single_bit;
  assign bus.out_count = out_count_q;
  assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_encoder_16x4_seq.sv
// tb_encoder_16x4_seq
// Drives an LSB-first and an MSB-first encoder in lockstep with identical
// stimulus and compares each against an index-list reference model.
module tb_encoder_16x4_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  encoder_16x4_seq_if bus_a ();
  encoder_16x4_seq_if bus_m ();

  encoder_16x4_seq #(.LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(bus_a.slave));
  encoder_16x4_seq #(.LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(bus_m.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    int          count;
    int          first_lsb;
    int          first_msb;
    int          stall_pct;
  } vec_t;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected emission order: set-bit indices sorted ascending or descending.
  function automatic void buildOrder(input logic [15:0] vec, output int qa[$], output int qm[$]);
    qa = {};
    qm = {};
    for (int i = 0; i < 16; i++) if (vec[i]) qa.push_back(i);
    for (int i = 15; i >= 0; i--) if (vec[i]) qm.push_back(i);
  endfunction

  // Called at a negedge with the DUTs idle; the vector is accepted at the
  // next posedge and control returns at the following negedge.
  task automatic applyStimulus(input logic [15:0] vec);
    checkOutput("in_ready_a_pre", bus_a.in_ready, 1);
    checkOutput("in_ready_m_pre", bus_m.in_ready, 1);
    bus_a.in_valid = 1'b1; bus_m.in_valid = 1'b1;
    bus_a.in = vec;        bus_m.in = vec;
    @(negedge clk);
    bus_a.in_valid = 1'b0; bus_m.in_valid = 1'b0;
    bus_a.in = 16'($urandom); bus_m.in = bus_a.in;
  endtask

  // Walk both DUTs through the emission of vec with random back-pressure.
  task automatic drain(input logic [15:0] vec, input int stall_pct, output int cycles);
    int qa[$];
    int qm[$];
    logic rdy;
    buildOrder(vec, qa, qm);
    cycles = 0;
    while (qa.size() > 0 && cycles < 200) begin
      checkOutput("out_valid_a", bus_a.out_valid, 1);
      checkOutput("out_valid_m", bus_m.out_valid, 1);
      checkOutput("out_a", bus_a.out, 16'(qa[0]));
      checkOutput("out_m", bus_m.out, 16'(qm[0]));
      checkOutput("out_last_a", bus_a.out_last, (qa.size() == 1));
      checkOutput("out_last_m", bus_m.out_last, (qm.size() == 1));
      checkOutput("in_ready_a_busy", bus_a.in_ready, 0);
      checkOutput("out_count_a", bus_a.out_count, 16'($countones(vec)));
      checkOutput("out_count_m", bus_m.out_count, 16'($countones(vec)));
      rdy = ($urandom_range(99) >= stall_pct);
      bus_a.out_ready = rdy; bus_m.out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        void'(qa.pop_front());
        void'(qm.pop_front());
      end
      cycles++;
    end
    if (qa.size() > 0) checkOutput("drain_timeout", 16'(qa.size()), 0);
    bus_a.out_ready = 1'b0; bus_m.out_ready = 1'b0;
    checkOutput("in_ready_a_after", bus_a.in_ready, 1);
    checkOutput("in_ready_m_after", bus_m.in_ready, 1);
    checkOutput("out_valid_a_after", bus_a.out_valid, 0);
    checkOutput("out_valid_m_after", bus_m.out_valid, 0);
  endtask

  task automatic zeroChecks();
    checkOutput("zero_err_a", bus_a.zero_err, 1);
    checkOutput("zero_err_m", bus_m.zero_err, 1);
    checkOutput("zero_out_valid", bus_a.out_valid, 0);
    checkOutput("zero_in_ready", bus_a.in_ready, 1);
    checkOutput("zero_out_count", bus_a.out_count, 0);
    @(negedge clk);
    checkOutput("zero_err_a_drop", bus_a.zero_err, 0);
    checkOutput("zero_err_m_drop", bus_m.zero_err, 0);
    checkOutput("zero_out_valid2", bus_a.out_valid, 0);
  endtask

  initial begin
    vec_t table_v[$];
    int   cycles;
    logic [15:0] v;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_m.in_valid = 1'b0;
    bus_a.in = 16'd0;      bus_m.in = 16'd0;
    bus_a.out_ready = 1'b0; bus_m.out_ready = 1'b0;

    table_v.push_back('{16'h0400, 1, 10, 10, 0});
    table_v.push_back('{16'h8001, 2, 0, 15, 0});
    table_v.push_back('{16'hFFFF, 16, 0, 15, 0});
    table_v.push_back('{16'h0024, 2, 2, 5, 50});
    table_v.push_back('{16'h0000, 0, 0, 0, 0});
    table_v.push_back('{16'h00F0, 4, 4, 7, 30});
    table_v.push_back('{16'h5A5A, 8, 1, 14, 40});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", bus_a.in_ready, 0);
    checkOutput("rst_out_valid", bus_a.out_valid, 0);
    checkOutput("rst_out_count", bus_a.out_count, 0);
    checkOutput("rst_zero_err", bus_a.zero_err, 0);
    checkOutput("rst_out", bus_a.out, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus_a.in_ready, 1);

    // Table-driven vectors
    foreach (table_v[k]) begin
      applyStimulus(table_v[k].vec);
      checkOutput("tbl_out_count", bus_a.out_count, 16'(table_v[k].count));
      if (table_v[k].count == 0) begin
        zeroChecks();
      end else begin
        checkOutput("tbl_first_a", bus_a.out, 16'(table_v[k].first_lsb));
        checkOutput("tbl_first_m", bus_m.out, 16'(table_v[k].first_msb));
        drain(table_v[k].vec, table_v[k].stall_pct, cycles);
        if (table_v[k].stall_pct == 0)
          checkOutput("tbl_drain_cycles", 16'(cycles), 16'(table_v[k].count));
      end
    end

    // Back-pressure: 0x0024 held for 3 cycles on index 2
    applyStimulus(16'h0024);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_valid", bus_a.out_valid, 1);
      checkOutput("stall_out_a", bus_a.out, 2);
      checkOutput("stall_out_m", bus_m.out, 5);
      checkOutput("stall_last", bus_a.out_last, 0);
      @(negedge clk);
    end
    drain(16'h0024, 0, cycles);

    // Reset in the middle of emitting 0x00F0
    applyStimulus(16'h00F0);
    checkOutput("rst_mid_first_a", bus_a.out, 4);
    checkOutput("rst_mid_first_m", bus_m.out, 7);
    bus_a.out_ready = 1'b1; bus_m.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_second_a", bus_a.out, 5);
    checkOutput("rst_mid_second_m", bus_m.out, 6);
    rst = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0; bus_m.out_ready = 1'b0;
    checkOutput("rst_mid_valid_a", bus_a.out_valid, 0);
    checkOutput("rst_mid_valid_m", bus_m.out_valid, 0);
    checkOutput("rst_mid_in_ready", bus_a.in_ready, 0);
    checkOutput("rst_mid_count", bus_a.out_count, 0);
    @(negedge clk);
    checkOutput("rst_mid_in_ready2", bus_a.in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_mid_no_valid_a", bus_a.out_valid, 0);
      checkOutput("rst_mid_no_valid_m", bus_m.out_valid, 0);
      checkOutput("rst_mid_ready_back", bus_a.in_ready, 1);
    end

    // Randomized vectors against the index-list model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0: v = 16'($urandom);
        1: v = 16'd1 << $urandom_range(15);
        2: v = (16'd1 << $urandom_range(15)) | (16'd1 << $urandom_range(15));
        default: v = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom);
      endcase
      applyStimulus(v);
      checkOutput("rnd_out_count", bus_a.out_count, 16'($countones(v)));
      if (v == 16'd0) zeroChecks();
      else drain(v, 30, cycles);
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
